// File: rtl/llc_pipe_sched_pkg.sv
// Shared constants and transaction-kind codes for the LLC pipeline scheduler.
// Slot records are declared where the widths are known, inside the scheduler.
package llc_pipe_sched_pkg;

  localparam int LLC_SET_BITS   = 8;
  localparam int LLC_KIND_BITS  = 3;
  localparam int LLC_CNT_BITS   = 16;
  localparam int LLC_PIPE_DEPTH = 4;

  // Codes 6 and 7 are reserved and behave like KIND_REQ.
  typedef enum logic [LLC_KIND_BITS-1:0] {
    KIND_RST    = 3'd0,
    KIND_FLUSH  = 3'd1,
    KIND_REQ    = 3'd2,
    KIND_RSP    = 3'd3,
    KIND_DMA_RD = 3'd4,
    KIND_DMA_WR = 3'd5
  } llc_kind_e;

endpackage

// File: rtl/llc_set_hazard_cmp.sv
// Compares an incoming set index against every pipeline slot and reports
// which valid slots hold the same set.
module llc_set_hazard_cmp #(
  parameter int SET_BITS = 8,
  parameter int N_SLOTS  = 4
) (
  input  logic [SET_BITS-1:0]              issue_set,
  input  logic [N_SLOTS-1:0]               slot_valid,
  input  logic [N_SLOTS-1:0][SET_BITS-1:0] slot_set,
  output logic [N_SLOTS-1:0]               match
);

  always_comb begin
    match = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      match[i] = slot_valid[i] && (slot_set[i] == issue_set);
    end
  end

endmodule

// File: rtl/llc_pipe_sched.sv
// Issue/hazard scheduler for READ_MEM -> LOOKUP -> PROCESS -> UPDATE: one slot per
// stage, same-set blocking so a set is never re-read before its UPDATE retires.
module llc_pipe_sched
  import llc_pipe_sched_pkg::*;
#(
  parameter int SET_BITS  = LLC_SET_BITS,
  parameter int KIND_BITS = LLC_KIND_BITS,
  parameter int CNT_BITS  = LLC_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [SET_BITS-1:0]  issue_set,
  input  logic [KIND_BITS-1:0] issue_kind,
  output logic                 issue_ready,
  input  logic                 flush_pipe,
  input  logic                 proc_done,
  output logic                 mem_en,
  output logic [SET_BITS-1:0]  mem_set,
  output logic                 lookup_en,
  output logic                 proc_en,
  output logic [SET_BITS-1:0]  proc_set,
  output logic [KIND_BITS-1:0] proc_kind,
  output logic                 upd_en,
  output logic [SET_BITS-1:0]  upd_set,
  output logic                 hazard_stall,
  output logic [2:0]           in_flight,
  output logic [CNT_BITS-1:0]  hazard_cnt
);

  localparam int N_SLOTS = LLC_PIPE_DEPTH;

  typedef struct packed {
    logic                 valid;
    logic [SET_BITS-1:0]  set;
    logic [KIND_BITS-1:0] kind;
  } llc_pipe_slot_t;

  // Index 0 is READ_MEM, 3 is UPDATE.
  llc_pipe_slot_t slot_q [N_SLOTS];

  logic [N_SLOTS-1:0]               slot_valid;
  logic [N_SLOTS-1:0][SET_BITS-1:0] slot_set;
  logic [N_SLOTS-1:0]               set_match;
  logic mv1, mv2, mv3;
  logic serialize, hazard, accept;

  always_comb begin
    slot_valid = '0;
    slot_set   = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      slot_valid[i] = slot_q[i].valid;
      slot_set[i]   = slot_q[i].set;
    end
  end

  llc_set_hazard_cmp #(
    .SET_BITS (SET_BITS),
    .N_SLOTS  (N_SLOTS)
  ) u_hazard_cmp (
    .issue_set  (issue_set),
    .slot_valid (slot_valid),
    .slot_set   (slot_set),
    .match      (set_match)
  );

  assign in_flight = 3'(slot_q[0].valid) + 3'(slot_q[1].valid)
                   + 3'(slot_q[2].valid) + 3'(slot_q[3].valid);

  // NOTE: every always_comb output is assigned before any condition so no latch is inferred.
  always_comb begin
    mv3 = 1'b0;
    mv2 = 1'b0;
    mv1 = 1'b0;
    serialize   = 1'b0;
    hazard      = 1'b0;
    issue_ready = 1'b0;
    accept      = 1'b0;

    // UPDATE always retires, so a slot moves whenever the one ahead leaves or is empty.
    mv3 = slot_q[2].valid && proc_done;
    mv2 = slot_q[1].valid && (!slot_q[2].valid || mv3);
    mv1 = slot_q[0].valid && (!slot_q[1].valid || mv2);

    // Reset, flush and response transactions must run alone in the pipe.
    serialize = ((issue_kind == KIND_BITS'(KIND_RST))   ||
                 (issue_kind == KIND_BITS'(KIND_FLUSH)) ||
                 (issue_kind == KIND_BITS'(KIND_RSP))) && (in_flight != 3'd0);
    hazard      = issue_valid && ((|set_match) || serialize);
    issue_ready = !rst && !flush_pipe && !hazard && (!slot_q[0].valid || mv1);
    accept      = issue_valid && issue_ready;
  end

  assign hazard_stall = hazard;

  // NOTE: state is updated with non-blocking assignments so every slot sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: set/kind fields are reset as well because they drive outputs that read 0 after reset.
      for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
      hazard_cnt <= '0;
    end else begin
      if (hazard && (hazard_cnt != '1)) hazard_cnt <= hazard_cnt + CNT_BITS'(1);

      if (flush_pipe) begin
        for (int i = 0; i < N_SLOTS; i++) slot_q[i].valid <= 1'b0;
      end else begin
        if (mv3) slot_q[3] <= slot_q[2];
        else     slot_q[3].valid <= 1'b0;

        if (mv2)      slot_q[2] <= slot_q[1];
        else if (mv3) slot_q[2].valid <= 1'b0;

        if (mv1)      slot_q[1] <= slot_q[0];
        else if (mv2) slot_q[1].valid <= 1'b0;

        if (accept)   slot_q[0] <= '{valid: 1'b1, set: issue_set, kind: issue_kind};
        else if (mv1) slot_q[0].valid <= 1'b0;
      end
    end
  end

  assign mem_en    = slot_q[0].valid;
  assign mem_set   = slot_q[0].set;
  assign lookup_en = slot_q[1].valid;
  assign proc_en   = slot_q[2].valid;
  assign proc_set  = slot_q[2].set;
  assign proc_kind = slot_q[2].kind;
  assign upd_en    = slot_q[3].valid;
  assign upd_set   = slot_q[3].set;

  // process_request must only report completion for an occupied PROCESS slot.
  a_proc_done_needs_slot: assert property (@(posedge clk) disable iff (rst)
    proc_done |-> slot_q[2].valid);

endmodule

// File: tb/tb_llc_pipe_sched.sv
// Scoreboarded bench for llc_pipe_sched: a transaction-queue model predicts
// every output each cycle; a separate monitor compares on the falling edge.
module tb_llc_pipe_sched;
  import llc_pipe_sched_pkg::*;

  localparam int          CB      = 16;
  localparam int unsigned CNT_MAX = (1 << CB) - 1;

  logic       clk = 1'b0;
  logic       rst, issue_valid, flush_pipe, proc_done;
  logic [7:0] issue_set;
  logic [2:0] issue_kind;
  logic       issue_ready, mem_en, lookup_en, proc_en, upd_en, hazard_stall;
  logic [7:0] mem_set, proc_set, upd_set;
  logic [2:0] proc_kind, in_flight;
  logic [CB-1:0] hazard_cnt;

  int total = 0;
  int bad   = 0;

  // Model: in-flight transactions, oldest first, each tagged with its stage 1..4.
  typedef struct {
    logic [7:0] set;
    logic [2:0] kind;
    int         stage;
  } txn_t;
  txn_t        pipe[$];
  logic [7:0]  exp_upd[$];
  int unsigned m_cnt   = 0;
  int          pd_mode = 1;
  bit          started = 1'b0;

  llc_pipe_sched dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_set    (issue_set),
    .issue_kind   (issue_kind),
    .issue_ready  (issue_ready),
    .flush_pipe   (flush_pipe),
    .proc_done    (proc_done),
    .mem_en       (mem_en),
    .mem_set      (mem_set),
    .lookup_en    (lookup_en),
    .proc_en      (proc_en),
    .proc_set     (proc_set),
    .proc_kind    (proc_kind),
    .upd_en       (upd_en),
    .upd_set      (upd_set),
    .hazard_stall (hazard_stall),
    .in_flight    (in_flight),
    .hazard_cnt   (hazard_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_stage(input int s);
    foreach (pipe[i]) if (pipe[i].stage == s) return i;
    return -1;
  endfunction

  // Stage s is free after this edge if empty or its occupant moves on.
  function automatic bit stage_vacates(input int s);
    bit vac   = 1'b1;
    bit moves = 1'b0;
    for (int k = 4; k >= s; k--) begin
      if (k == 4)      moves = 1'b1;
      else if (k == 3) moves = (proc_done == 1'b1);
      else             moves = vac;
      vac = (find_stage(k) < 0) || moves;
    end
    return vac;
  endfunction

  function automatic bit model_hazard();
    bit same_set = 1'b0;
    bit alone    = (issue_kind inside {3'd0, 3'd1, 3'd3}) && (pipe.size() != 0);
    foreach (pipe[i]) if (pipe[i].set == issue_set) same_set = 1'b1;
    return (issue_valid == 1'b1) && (same_set || alone);
  endfunction

  function automatic bit model_ready();
    return !rst && !flush_pipe && !model_hazard() && stage_vacates(1);
  endfunction

  // Reference model and scoreboard producer: advance on each rising edge.
  initial begin
    bit   acc;
    txn_t t;
    txn_t nxt[$];
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (rst) begin
        pipe.delete();
        exp_upd.delete();
        m_cnt = 0;
      end else begin
        acc = issue_valid && model_ready();
        if (model_hazard() && m_cnt < CNT_MAX) m_cnt++;
        if (flush_pipe) begin
          pipe.delete();
          exp_upd.delete();
        end else begin
          nxt.delete();
          foreach (pipe[i]) begin
            t = pipe[i];
            if (t.stage == 4) continue;
            if ((t.stage == 3) ? (proc_done == 1'b1) : stage_vacates(t.stage + 1)) t.stage++;
            nxt.push_back(t);
          end
          pipe = nxt;
          if (acc) begin
            pipe.push_back('{set: issue_set, kind: issue_kind, stage: 1});
            exp_upd.push_back(issue_set);
          end
        end
      end
    end
  end

  // Monitor: compare every output against the model away from the active edge.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (!started) continue;
      check("mem_en",       mem_en,       find_stage(1) >= 0);
      check("lookup_en",    lookup_en,    find_stage(2) >= 0);
      check("proc_en",      proc_en,      find_stage(3) >= 0);
      check("upd_en_model", upd_en,       find_stage(4) >= 0);
      check("in_flight",    in_flight,    pipe.size());
      check("issue_ready",  issue_ready,  model_ready());
      check("hazard_stall", hazard_stall, model_hazard());
      check("hazard_cnt",   hazard_cnt,   m_cnt);
      idx = find_stage(1);
      if (mem_en && idx >= 0) check("mem_set", mem_set, pipe[idx].set);
      idx = find_stage(3);
      if (proc_en && idx >= 0) begin
        check("proc_set",  proc_set,  pipe[idx].set);
        check("proc_kind", proc_kind, pipe[idx].kind);
      end
      if (upd_en) begin
        if (exp_upd.size() == 0) check("upd_no_expect", upd_en, 1'b0);
        else                     check("upd_set", upd_set, exp_upd.pop_front());
      end
    end
  end

  // process_request stand-in: completes only when the model has a PROCESS occupant.
  initial begin
    proc_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (pd_mode)
        0:       proc_done = 1'b0;
        1:       proc_done = (find_stage(3) >= 0);
        default: proc_done = (find_stage(3) >= 0) && ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [7:0] s, input logic [2:0] k);
    bit ok = 1'b0;
    issue_valid = 1'b1;
    issue_set   = s;
    issue_kind  = k;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = issue_ready;
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b0;
    if (!ok) check("issue_accept", ok, 1'b1);
  endtask

  initial begin
    int unsigned c0;
    rst = 1'b1; issue_valid = 1'b0; issue_set = '0; issue_kind = '0; flush_pipe = 1'b0;

    // Reset held three cycles: everything reads zero, nothing is accepted.
    tick(3);
    @(negedge clk);
    check("rst_mem_set",   mem_set,     8'h00);
    check("rst_proc_set",  proc_set,    8'h00);
    check("rst_proc_kind", proc_kind,   3'd0);
    check("rst_upd_set",   upd_set,     8'h00);
    check("rst_ready",     issue_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // First idle cycle after reset accepts; then 01,02,03 back-to-back.
    pd_mode = 1;
    issue_valid = 1'b1; issue_set = 8'h01; issue_kind = KIND_REQ;
    @(negedge clk);
    check("ready_after_reset", issue_ready, 1'b1);
    @(posedge clk); #1;
    issue(8'h02, KIND_REQ);
    issue(8'h03, KIND_REQ);
    tick(6);

    // Same-set back-to-back: second waits four hazard cycles.
    c0 = m_cnt;
    issue(8'h10, KIND_REQ);
    issue(8'h10, KIND_REQ);
    @(negedge clk);
    check("same_set_stall", hazard_cnt, c0 + 4);
    @(posedge clk); #1;
    tick(6);

    // PROCESS held: upstream compresses, issue_ready drops, then drains in order.
    pd_mode = 0;
    issue(8'h20, KIND_REQ);
    issue(8'h21, KIND_REQ);
    issue(8'h22, KIND_REQ);
    issue_valid = 1'b1; issue_set = 8'h23; issue_kind = KIND_REQ;
    tick(10);
    @(negedge clk);
    check("hold_in_flight", in_flight,   3'd3);
    check("hold_ready",     issue_ready, 1'b0);
    check("hold_upd_en",    upd_en,      1'b0);
    @(posedge clk); #1;
    pd_mode = 1;
    issue(8'h23, KIND_REQ);
    tick(8);

    // RSP waits for an empty pipe even on a different set.
    pd_mode = 0;
    issue(8'h31, KIND_REQ);
    tick(3);
    c0 = m_cnt;
    fork
      issue(8'h30, KIND_RSP);
      begin
        tick(4);
        pd_mode = 1;
      end
    join
    @(negedge clk);
    check("rsp_serialize_stall", hazard_cnt, c0 + 6);
    @(posedge clk); #1;
    tick(6);

    // Flush with three valid slots and proc_done in the same cycle.
    pd_mode = 0;
    issue(8'h40, KIND_REQ);
    issue(8'h41, KIND_DMA_RD);
    issue(8'h42, KIND_DMA_WR);
    c0 = m_cnt;
    flush_pipe = 1'b1;
    pd_mode = 1;
    @(posedge clk); #1;
    flush_pipe = 1'b0;
    @(negedge clk);
    check("flush_in_flight", in_flight,  3'd0);
    check("flush_upd_en",    upd_en,     1'b0);
    check("flush_cnt_kept",  hazard_cnt, c0);
    @(negedge clk);
    check("flush_upd_en_2",  upd_en,     1'b0);
    @(posedge clk); #1;

    // Randomised traffic over a small set range to provoke hazards.
    pd_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_set   = 8'($urandom_range(0, 7));
      issue_kind  = ($urandom_range(0, 3) != 0) ? 3'(KIND_REQ) : 3'($urandom_range(0, 7));
      flush_pipe  = ($urandom_range(0, 63) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    issue_valid = 1'b0; flush_pipe = 1'b0; rst = 1'b0;
    pd_mode = 1;
    tick(10);
    @(negedge clk);
    check("drained_in_flight", in_flight, 3'd0);
    check("scoreboard_empty",  exp_upd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
